usb_byte_serializer: RTL

USB_BYTE_SERIALIZER -- requirements
Module: usb_byte_serializer

---
 rtl/usb_byte_serializer_if.sv | 25 ++
 rtl/usb_byte_serializer.sv | 68 ++++++
 2 files changed

// File: rtl/usb_byte_serializer_if.sv
// Handshake and byte-bus bundle between the upstream arbiter, the USB side and the serializer.
interface usb_byte_serializer_if #(parameter int DEPTH = 4);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   WORD_DATA;
  logic          WORD_VALID;
  logic          WORD_READY;
  logic          USB_READ;
  logic [7:0]    USB_DATA;
  logic          BYTE_AVAIL;
  logic [CW-1:0] WORD_COUNT;
  logic          FLUSH;
  logic          ERR_CLEAR;
  logic          READ_ERROR;

  modport master (
    output WORD_DATA, WORD_VALID, USB_READ, FLUSH, ERR_CLEAR,
    input  WORD_READY, USB_DATA, BYTE_AVAIL, WORD_COUNT, READ_ERROR
  );

  modport slave (
    input  WORD_DATA, WORD_VALID, USB_READ, FLUSH, ERR_CLEAR,
    output WORD_READY, USB_DATA, BYTE_AVAIL, WORD_COUNT, READ_ERROR
  );
endinterface

// File: rtl/usb_byte_serializer.sv
// 32-bit word buffer drained one byte at a time (LSB first) by USB read strobes.
module usb_byte_serializer #(
  parameter int DEPTH = 4
) (
  input logic                  BUS_CLK,
  input logic                  BUS_RST_B,
  usb_byte_serializer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [1:0]    bidx;
  logic          read_error;

  logic          avail, push, pop_byte, pop_word, rd_err;
  logic [31:0]   head;

  assign avail    = (count != '0);
  assign push     = bus.WORD_VALID & bus.WORD_READY & ~bus.FLUSH;
  assign pop_byte = bus.USB_READ & avail & ~bus.FLUSH;
  assign pop_word = pop_byte & (bidx == 2'd3);
  // An empty read is an error even while flushing; flush never touches the flag.
  assign rd_err   = bus.USB_READ & ~avail;
  assign head     = mem[rd_ptr];

  assign bus.WORD_READY = (count < CW'(DEPTH));
  assign bus.BYTE_AVAIL = avail;
  assign bus.WORD_COUNT = count;
  assign bus.READ_ERROR = read_error;
  assign bus.USB_DATA   = avail ? head[8*bidx +: 8] : 8'h00;

  // Storage holds data only; control state below decides what is valid.
  always_ff @(posedge BUS_CLK) begin
    if (push) mem[wr_ptr] <= bus.WORD_DATA;
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_B) begin
    if (!BUS_RST_B) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      bidx   <= '0;
    end else if (bus.FLUSH) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      bidx   <= '0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + 1'b1;
      if (pop_word) rd_ptr <= rd_ptr + 1'b1;
      if (pop_byte) bidx   <= bidx + 2'd1;
      case ({push, pop_word})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_B) begin
    if (!BUS_RST_B)         read_error <= 1'b0;
    else if (rd_err)        read_error <= 1'b1;
    else if (bus.ERR_CLEAR) read_error <= 1'b0;
  end
endmodule
